// File: rtl/logic_op_pipe.sv
// Selectable two-operand bitwise gate feeding a small result FIFO with
// valid/ready on both sides, a per-result zero flag and an accept counter.

module logic_op_lane (
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);
    always_comb begin
        y = 1'b0;
        unique case (op)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = a ^ b;
            3'd3: y = ~(a & b);
            3'd4: y = ~(a | b);
            3'd5: y = ~(a ^ b);
            3'd6: y = a & ~b;
            3'd7: y = ~a;
        endcase
    end
endmodule

module logic_op_pipe #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic [2:0]                        op,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out,
    output logic                              out_zero,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]                  acc_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH+1);

    typedef struct packed {
        logic             zero;
        logic [WIDTH-1:0] res;
    } entry_t;

    logic [WIDTH-1:0] res;
    entry_t           mem [FIFO_DEPTH];
    entry_t           head;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_op_lane u_lane (.a(a[i]), .b(b[i]), .op(op), .y(res[i]));
    end

    // Flow control looks only at registered occupancy: no full-bypass, no flow-through.
    assign in_ready  = (level != LW'(FIFO_DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head     = mem[rd_ptr];
    assign out      = out_valid ? head.res  : '0;
    assign out_zero = out_valid ? head.zero : 1'b0;

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{zero: (res == '0), res: res};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            acc_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule
